// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives the 6-bit PC and ROM enable, follows decode redirects,
// and flags which 1-cycle-late ROM outputs are valid, non-squashed instructions.
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                ce_q, ce_d;
  logic                inst_valid_q, inst_valid_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    fetch_cnt_q, fetch_cnt_d;

  // Next-state and registered-output logic; halt beats redirect beats stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = 1'b0;
    inst_pc_d    = inst_pc_q;
    fetch_cnt_d  = fetch_cnt_q + CNT_W'(inst_valid_q);

    case (state_q)
      S_IDLE: begin
        pc_d = PC_RST;
        if (start) begin
          state_d     = S_FETCH;
          fetch_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (br_valid) begin
          pc_d = br_target;
        end else if (!stall) begin
          pc_d         = pc_q + ADDR_W'(1);
          inst_valid_d = 1'b1;
          inst_pc_d    = pc_q;
        end
      end
      S_HALT: begin
        if (start && !halt_req) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    ce_d     = (state_d == S_FETCH);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RST;
      ce_q         <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      halted_q     <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      halted_q     <= halted_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign ce         = ce_q;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign halted     = halted_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset/idle, sequential wrap, redirect,
// stall and branch/stall conflict, halt/resume, and asynchronous reset mid-run.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [5:0]  br_target = '0;
  logic [5:0]  pc;
  logic        ce;
  logic        inst_valid;
  logic [5:0]  inst_pc;
  logic        halted;
  logic [15:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt_req   (halt_req),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .pc         (pc),
    .ce         (ce),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .halted     (halted),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then pulse start so that fetching begins at pc 0.
  task automatic restart();
    rst_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; stall = 1'b0; br_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic advance_to_pc(input logic [5:0] target);
    for (int i = 0; i < 200 && pc != target; i++) tick();
    check_eq("reach_pc", 32'(pc), 32'(target));
  endtask

  logic [15:0] cnt_hold;

  initial begin
    // Reset held 3 cycles, then idle with start low.
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_pc", 32'(pc), 0);
    check_eq("rst_ce", 32'(ce), 0);
    check_eq("rst_iv", 32'(inst_valid), 0);
    check_eq("rst_ipc", 32'(inst_pc), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_cnt", 32'(fetch_cnt), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_pc", 32'(pc), 0);
      check_eq("idle_ce", 32'(ce), 0);
      check_eq("idle_iv", 32'(inst_valid), 0);
      check_eq("idle_cnt", 32'(fetch_cnt), 0);
    end

    // Start: ce and pc=0 from the sampling edge, first valid one edge later.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_ce", 32'(ce), 1);
    check_eq("start_pc", 32'(pc), 0);
    check_eq("start_iv", 32'(inst_valid), 0);
    for (int k = 1; k <= 70; k++) begin
      tick();
      check_eq("seq_iv", 32'(inst_valid), 1);
      check_eq("seq_ipc", 32'(inst_pc), 32'((k - 1) % 64));
      check_eq("seq_pc", 32'(pc), 32'(k % 64));
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("seq_cnt70", 32'(fetch_cnt), 70);

    // Redirect at pc 10 to 40: 8, 9, bubble, 40, 41.
    restart();
    advance_to_pc(6'd10);
    check_eq("br_pre_ipc", 32'(inst_pc), 9);
    br_valid = 1'b1; br_target = 6'd40;
    tick();
    br_valid = 1'b0; br_target = 6'd0;
    check_eq("br_bubble", 32'(inst_valid), 0);
    check_eq("br_pc", 32'(pc), 40);
    tick();
    check_eq("br_t_iv", 32'(inst_valid), 1);
    check_eq("br_t_ipc", 32'(inst_pc), 40);
    tick();
    check_eq("br_t1_ipc", 32'(inst_pc), 41);

    // Stall 3 cycles at pc 5, then branch+stall conflict.
    restart();
    advance_to_pc(6'd5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_iv", 32'(inst_valid), 0);
      check_eq("stall_pc", 32'(pc), 5);
    end
    stall = 1'b0;
    tick();
    check_eq("unstall_iv", 32'(inst_valid), 1);
    check_eq("unstall_ipc", 32'(inst_pc), 5);
    tick();
    check_eq("unstall_ipc1", 32'(inst_pc), 6);
    stall = 1'b1; br_valid = 1'b1; br_target = 6'd20;
    tick();
    stall = 1'b0; br_valid = 1'b0;
    check_eq("conf_iv", 32'(inst_valid), 0);
    check_eq("conf_pc", 32'(pc), 20);
    tick();
    check_eq("conf_ipc", 32'(inst_pc), 20);
    check_eq("conf_iv1", 32'(inst_valid), 1);

    // Halt at pc 12 (with a simultaneous branch that must be discarded), hold, resume.
    restart();
    advance_to_pc(6'd12);
    halt_req = 1'b1; br_valid = 1'b1; br_target = 6'd33;
    tick();
    halt_req = 1'b0;
    check_eq("halt_halted", 32'(halted), 1);
    check_eq("halt_ce", 32'(ce), 0);
    check_eq("halt_iv", 32'(inst_valid), 0);
    check_eq("halt_pc", 32'(pc), 12);
    check_eq("halt_cnt", 32'(fetch_cnt), 12);
    cnt_hold = fetch_cnt;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      tick();
      check_eq("hold_pc", 32'(pc), 12);
      check_eq("hold_halted", 32'(halted), 1);
      check_eq("hold_cnt", 32'(fetch_cnt), 32'(cnt_hold));
    end
    br_valid = 1'b0; stall = 1'b0;
    start = 1'b1; halt_req = 1'b1;
    tick();
    check_eq("both_halted", 32'(halted), 1);
    halt_req = 1'b0;
    tick();
    start = 1'b0;
    check_eq("resume_ce", 32'(ce), 1);
    check_eq("resume_halted", 32'(halted), 0);
    check_eq("resume_pc", 32'(pc), 12);
    tick();
    check_eq("resume_iv", 32'(inst_valid), 1);
    check_eq("resume_ipc", 32'(inst_pc), 12);
    check_eq("resume_cnt", 32'(fetch_cnt), 12);

    // Asynchronous reset between edges at pc 30.
    restart();
    advance_to_pc(6'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pc", 32'(pc), 0);
    check_eq("arst_ce", 32'(ce), 0);
    check_eq("arst_iv", 32'(inst_valid), 0);
    check_eq("arst_cnt", 32'(fetch_cnt), 0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("post_arst_ce", 32'(ce), 0);
    check_eq("post_arst_pc", 32'(pc), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Sequences the 6-bit program counter and instruction-ROM enable for the core's fetch stage.
- After `start`, issues one fetch per cycle and follows redirects from decode.
- Holds the PC under stall and halt, and marks which ROM outputs are valid, non-squashed instructions.
- Sits between the instruction ROM (synchronous, 1-cycle read) and the decode stage.

## Interface
Parameters:
- `ADDR_W`, 6, PC / ROM address width.
- `RESET_PC`, 0, PC value after reset.
- `CNT_W`, 16, width of the retired-fetch counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled each edge; begins or resumes fetching.
- `halt_req`  in  1  stop fetching and hold the PC.
- `stall`  in  1  decode cannot accept; hold the PC.
- `br_valid`  in  1  redirect request from decode.
- `br_target`  in  ADDR_W  redirect address.
- `pc`  out  ADDR_W  registered ROM address.
- `ce`  out  1  registered ROM enable.
- `inst_valid`  out  1  ROM data this cycle is a valid instruction.
- `inst_pc`  out  ADDR_W  address of the instruction flagged by `inst_valid`.
- `halted`  out  1  state is HALT.
- `fetch_cnt`  out  CNT_W  count of cycles with `inst_valid` = 1.

## Operation
States: IDLE, FETCH, HALT (registered).

Reset (`rst_n` = 0, asynchronous, any state):
- State = IDLE, `pc` = RESET_PC, `ce` = 0.
- `inst_valid` = 0, `inst_pc` = 0, `halted` = 0, `fetch_cnt` = 0.

IDLE:
- `pc` held at RESET_PC.
- `start` = 1 → FETCH; `fetch_cnt` cleared to 0.
- All other inputs are ignored.

FETCH:
- `ce` = 1; ROM reads `pc`. Next-edge priority, highest first:
  - `halt_req`: fetch squashed, `pc` held, → HALT.
  - `br_valid`: fetch squashed, `pc` ← `br_target`.
  - `stall`: fetch squashed, `pc` held; ROM re-reads the same address while stalled.
  - Otherwise: fetch accepted, `pc` ← `pc` + 1 mod 2^ADDR_W (63 → 0 wraps silently).
- `start` is ignored.

HALT:
- `ce` = 0, `pc` held, `halted` = 1.
- `start` = 1 and `halt_req` = 0 → FETCH; resumes at the held `pc` (the squashed address is re-fetched).
- `start` and `halt_req` both 1 → remain in HALT.
- `br_valid` and `stall` are ignored.

Outputs:
- `ce` = 1 exactly when state = FETCH.
- `inst_valid` next = fetch accepted this cycle; `inst_pc` next = current `pc` when accepted, otherwise held.
- `fetch_cnt` increments when `inst_valid` = 1; wraps at 2^CNT_W.

## Timing
- `start` sampled at edge E → `ce` = 1 with `pc` = RESET_PC from E; first `inst_valid` = 1 (`inst_pc` = RESET_PC) from edge E+1.
- Steady state: one instruction per cycle; `inst_valid`/`inst_pc` lag `pc` by exactly one cycle, aligned with ROM data.
- Redirect at edge E:
  - ROM output in cycle E..E+1 is squashed (`inst_valid` = 0).
  - `pc` = `br_target` from E.
  - Target instruction is valid from E+1. Redirect penalty: 1 bubble.
- Stall over N cycles: N cycles of `inst_valid` = 0; `pc` unchanged throughout.
- `halt_req` at edge E: `ce` = 0 and `halted` = 1 from E; `inst_valid` = 0 from E.
- `br_valid` with `stall`: branch wins.
- `halt_req` with `br_valid`: halt wins; target discarded.
- Reset mid-run: all outputs return to reset values immediately, without waiting for a clock edge; no partial fetch survives.

## Test plan
- Reset then idle: hold `rst_n` = 0 for 3 cycles, release, `start` = 0 for 5 cycles → `pc` = 0, `ce` = 0, `inst_valid` = 0, `fetch_cnt` = 0 throughout.
- Sequential run and wrap: `start` pulse, free-run 70 cycles → `inst_pc` sequence 0, 1, …, 63, 0, …, 5 with no gaps; `fetch_cnt` = 70.
- Redirect: at `pc` = 10, pulse `br_valid` with `br_target` = 40 → valid `inst_pc` sequence 8, 9, bubble, 40, 41; address 10 never valid.
- Stall and conflict:
  - `stall` for 3 cycles at `pc` = 5 → 3 bubbles, then 5, 6 valid.
  - `stall` and `br_valid` (target 20) together → next valid `inst_pc` = 20.
- Halt/resume: `halt_req` at `pc` = 12 → `halted` = 1, `ce` = 0, `pc` = 12 held 10 cycles; then `start` → first valid `inst_pc` = 12; `fetch_cnt` unchanged during HALT.
- Async reset mid-run: drop `rst_n` between edges while `pc` = 30 → `pc` = 0, `ce` = 0, `inst_valid` = 0 before the next edge; state IDLE after release.
